// File: rtl/bisr_ru_allocator_os.sv
// bisr_ru_allocator_os
// Snapshots the STW fault map, scans it one PE per cycle to hand out up to
// NUM_RU recompute-unit slots, flags overflow as unrepairable, and then
// substitutes valid RU results into the registered bottom-output bus.
module bisr_ru_allocator_os #(
    parameter  int ROWS      = 4,
    parameter  int COLS      = 4,
    parameter  int WORD_SIZE = 16,
    parameter  int NUM_RU    = 4,
    parameter  int SCAN_MODE = 0,
    localparam int RW        = $clog2(ROWS),
    localparam int CW        = $clog2(COLS),
    localparam int FCW       = $clog2(ROWS*COLS+1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stw_complete,
    input  logic [ROWS*COLS-1:0]        stw_result_mat,
    input  logic                        alloc_start,
    input  logic [COLS*WORD_SIZE-1:0]   systolic_bottom_out,
    input  logic [NUM_RU*WORD_SIZE-1:0] rcm_bottom_out,
    input  logic [NUM_RU-1:0]           ru_output_valid,
    output logic [NUM_RU-1:0]           ru_en,
    output logic [RW*NUM_RU-1:0]        ru_row_mapping,
    output logic [CW*NUM_RU-1:0]        ru_col_mapping,
    output logic [FCW-1:0]              fault_count,
    output logic                        unrepairable,
    output logic                        alloc_done,
    output logic [COLS*WORD_SIZE-1:0]   merged_bottom_out
);

    localparam int NPE = ROWS*COLS;
    localparam int IW  = $clog2(NPE);
    localparam int SW  = $clog2(NUM_RU+1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [NPE-1:0]         r_snap;
    logic [FCW-1:0]         r_idx;
    logic [RW-1:0]          r_row;
    logic [CW-1:0]          r_col;
    logic [SW-1:0]          r_slot;
    logic [NUM_RU-1:0]      r_ru_en;
    logic [RW-1:0]          r_row_map [NUM_RU];
    logic [CW-1:0]          r_col_map [NUM_RU];
    logic [FCW-1:0]         r_fault_count;
    logic                   r_unrep;
    logic                   r_done;
    logic [COLS*WORD_SIZE-1:0] r_merged;

    logic                   w_start;
    logic                   w_scan_end;
    logic [IW-1:0]          w_pe_idx;
    logic                   w_pe_faulty;
    logic                   w_slot_free;
    logic                   w_row_last;
    logic                   w_col_last;
    logic [COLS*WORD_SIZE-1:0] w_merge_next;

    // A new allocation may begin from IDLE or DONE, never mid-scan, and only
    // once the fault map is stable.
    assign w_start     = alloc_start && stw_complete && (r_state != S_SCAN);

    // The index runs one past the last PE so that the finishing step takes
    // its own edge after the final visit.
    assign w_scan_end  = (r_idx == FCW'(NPE));

    // Row/column are tracked as cursors instead of dividing the index.
    assign w_pe_idx    = IW'(r_row) * IW'(COLS) + IW'(r_col);
    assign w_pe_faulty = (r_state == S_SCAN) && !w_scan_end && r_snap[w_pe_idx];
    assign w_slot_free = (r_slot != SW'(NUM_RU));
    assign w_row_last  = (r_row == RW'(ROWS-1));
    assign w_col_last  = (r_col == CW'(COLS-1));

    // Allocation FSM: snapshot on start, one PE per cycle, then hold results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_snap        <= '0;
            r_idx         <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_slot        <= '0;
            r_ru_en       <= '0;
            r_fault_count <= '0;
            r_unrep       <= 1'b0;
            r_done        <= 1'b0;
            for (int k = 0; k < NUM_RU; k++) begin
                r_row_map[k] <= '0;
                r_col_map[k] <= '0;
            end
        end else if (w_start) begin
            r_state       <= S_SCAN;
            r_snap        <= stw_result_mat;
            r_idx         <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_slot        <= '0;
            r_ru_en       <= '0;
            r_fault_count <= '0;
            r_unrep       <= 1'b0;
            r_done        <= 1'b0;
            for (int k = 0; k < NUM_RU; k++) begin
                r_row_map[k] <= '0;
                r_col_map[k] <= '0;
            end
        end else if (r_state == S_SCAN) begin
            if (w_scan_end) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
            end else begin
                r_idx <= r_idx + FCW'(1);
                // Row-major walks columns fastest; column-major walks rows.
                if (SCAN_MODE == 0) begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= w_row_last ? '0 : r_row + RW'(1);
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end else begin
                    if (w_row_last) begin
                        r_row <= '0;
                        r_col <= w_col_last ? '0 : r_col + CW'(1);
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end
                if (w_pe_faulty) begin
                    r_fault_count <= r_fault_count + FCW'(1);
                    if (w_slot_free) begin
                        for (int k = 0; k < NUM_RU; k++) begin
                            if (r_slot == SW'(k)) begin
                                r_ru_en[k]   <= 1'b1;
                                r_row_map[k] <= r_row;
                                r_col_map[k] <= r_col;
                            end
                        end
                        r_slot <= r_slot + SW'(1);
                    end else begin
                        r_unrep <= 1'b1;
                    end
                end
            end
        end
    end

    // Per-column output select; slots are searched from the top down so that
    // the lowest matching slot index is the one left standing.
    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            logic [WORD_SIZE-1:0] w_word;
            // Choose between the array column and a covering RU result.
            always_comb begin
                w_word = systolic_bottom_out[gi*WORD_SIZE +: WORD_SIZE];
                if (r_state == S_DONE) begin
                    for (int k = NUM_RU-1; k >= 0; k--) begin
                        if (r_ru_en[k] && ru_output_valid[k] &&
                            (r_col_map[k] == CW'(gi))) begin
                            w_word = rcm_bottom_out[k*WORD_SIZE +: WORD_SIZE];
                        end
                    end
                end
            end
            assign w_merge_next[gi*WORD_SIZE +: WORD_SIZE] = w_word;
        end

        for (gi = 0; gi < NUM_RU; gi++) begin : g_map
            assign ru_row_mapping[gi*RW +: RW] = r_row_map[gi];
            assign ru_col_mapping[gi*CW +: CW] = r_col_map[gi];
        end
    endgenerate

    // Merged bus is refreshed every cycle with one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_merged <= '0;
        end else begin
            r_merged <= w_merge_next;
        end
    end

    assign ru_en             = r_ru_en;
    assign fault_count       = r_fault_count;
    assign unrepairable      = r_unrep;
    assign alloc_done        = r_done;
    assign merged_bottom_out = r_merged;

endmodule

// File: tb/tb_bisr_ru_allocator_os.sv
// Directed bench for bisr_ru_allocator_os: a row-major and a column-major
// instance share every input; expected values are hand-derived constants.
module tb_bisr_ru_allocator_os;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stw_complete = 1'b0;
    logic [15:0] stw_result_mat = '0;
    logic        alloc_start = 1'b0;
    logic [63:0] systolic_bottom_out = '0;
    logic [63:0] rcm_bottom_out = '0;
    logic [3:0]  ru_output_valid = '0;

    logic [3:0]  ru_en0, ru_en1;
    logic [7:0]  row_map0, row_map1, col_map0, col_map1;
    logic [4:0]  fc0, fc1;
    logic        unrep0, unrep1, done0, done1;
    logic [63:0] merged0, merged1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bisr_ru_allocator_os #(.ROWS(4), .COLS(4), .WORD_SIZE(16), .NUM_RU(4), .SCAN_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .stw_complete(stw_complete), .stw_result_mat(stw_result_mat),
        .alloc_start(alloc_start), .systolic_bottom_out(systolic_bottom_out),
        .rcm_bottom_out(rcm_bottom_out), .ru_output_valid(ru_output_valid),
        .ru_en(ru_en0), .ru_row_mapping(row_map0), .ru_col_mapping(col_map0),
        .fault_count(fc0), .unrepairable(unrep0), .alloc_done(done0),
        .merged_bottom_out(merged0)
    );

    bisr_ru_allocator_os #(.ROWS(4), .COLS(4), .WORD_SIZE(16), .NUM_RU(4), .SCAN_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .stw_complete(stw_complete), .stw_result_mat(stw_result_mat),
        .alloc_start(alloc_start), .systolic_bottom_out(systolic_bottom_out),
        .rcm_bottom_out(rcm_bottom_out), .ru_output_valid(ru_output_valid),
        .ru_en(ru_en1), .ru_row_mapping(row_map1), .ru_col_mapping(col_map1),
        .fault_count(fc1), .unrepairable(unrep1), .alloc_done(done1),
        .merged_bottom_out(merged1)
    );

    // Starts an allocation and counts rising edges after the sampling edge
    // until alloc_done is seen; -1 if it never rises. With disturb set, the
    // map is flipped to all-faulty and alloc_start re-pulsed mid-scan.
    task automatic run_alloc(input logic [15:0] map, input bit disturb, output int edges);
        @(negedge clk);
        stw_result_mat = map;
        stw_complete   = 1'b1;
        alloc_start    = 1'b1;
        @(negedge clk);
        alloc_start = 1'b0;
        edges = 0;
        while (1) begin
            @(posedge clk);
            edges++;
            #1;
            if (done0) break;
            if (disturb && edges == 5) begin
                stw_result_mat = 16'hFFFF;
                alloc_start    = 1'b1;
            end
            if (disturb && edges == 6) alloc_start = 1'b0;
            if (edges > 40) begin
                edges = -1;
                break;
            end
        end
        alloc_start = 1'b0;
    endtask

    task automatic test_reset();
        systolic_bottom_out = 64'h1234_5678_9ABC_DEF0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({ru_en0, row_map0, col_map0, fc0, unrep0, done0} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got en=%b row=%h col=%h fc=%0d un=%b done=%b, want all 0",
                     ru_en0, row_map0, col_map0, fc0, unrep0, done0);
        end
        n_vec++;
        if (merged0 !== 64'h0) begin
            n_err++;
            $display("FAIL reset_merged: got %h want 0", merged0);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_ignore_no_complete();
        @(negedge clk);
        stw_result_mat = 16'h0001;
        stw_complete   = 1'b0;
        alloc_start    = 1'b1;
        @(negedge clk);
        alloc_start = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++;
        if (done0 !== 1'b0 || ru_en0 !== 4'b0 || fc0 !== 5'd0) begin
            n_err++;
            $display("FAIL ignore_no_complete: got done=%b en=%b fc=%0d want 0/0000/0",
                     done0, ru_en0, fc0);
        end
        $display("test_ignore_no_complete done");
    endtask

    task automatic test_empty_map();
        int edges;
        run_alloc(16'h0000, 1'b0, edges);
        n_vec++;
        if (edges !== 17) begin
            n_err++;
            $display("FAIL empty_latency: got %0d edges want 17", edges);
        end
        n_vec++;
        if (ru_en0 !== 4'b0 || fc0 !== 5'd0 || unrep0 !== 1'b0) begin
            n_err++;
            $display("FAIL empty_result: got en=%b fc=%0d un=%b want 0000/0/0", ru_en0, fc0, unrep0);
        end
        @(negedge clk);
        systolic_bottom_out = 64'h0102_0304_0506_0708;
        ru_output_valid = 4'hF;
        @(posedge clk);
        #1;
        systolic_bottom_out = 64'hA0A1_A2A3_A4A5_A6A7;
        #1;
        n_vec++;
        if (merged0 !== 64'h0102_0304_0506_0708) begin
            n_err++;
            $display("FAIL passthru_hold: got %h want 0102030405060708", merged0);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (merged0 !== 64'hA0A1_A2A3_A4A5_A6A7) begin
            n_err++;
            $display("FAIL passthru_next: got %h want a0a1a2a3a4a5a6a7", merged0);
        end
        ru_output_valid = 4'h0;
        $display("test_empty_map done edges=%0d", edges);
    endtask

    task automatic test_single_fault_merge();
        int edges;
        run_alloc(16'h0200, 1'b1, edges);
        n_vec++;
        if (edges !== 17) begin
            n_err++;
            $display("FAIL single_latency: got %0d edges want 17", edges);
        end
        n_vec++;
        if (ru_en0 !== 4'b0001 || row_map0 !== 8'h02 || col_map0 !== 8'h01 || fc0 !== 5'd1) begin
            n_err++;
            $display("FAIL single_alloc: got en=%b row=%h col=%h fc=%0d want 0001/02/01/1",
                     ru_en0, row_map0, col_map0, fc0);
        end
        @(negedge clk);
        systolic_bottom_out = {16'h4444, 16'h3333, 16'h1111, 16'h0AAA};
        rcm_bottom_out      = {16'hD00D, 16'hCAFE, 16'hDEAD, 16'hBEEF};
        ru_output_valid     = 4'b1111;
        @(negedge clk);
        n_vec++;
        if (merged0 !== {16'h4444, 16'h3333, 16'hBEEF, 16'h0AAA}) begin
            n_err++;
            $display("FAIL single_merge: got %h want 44443333beef0aaa", merged0);
        end
        ru_output_valid = 4'b0000;
        @(negedge clk);
        n_vec++;
        if (merged0 !== {16'h4444, 16'h3333, 16'h1111, 16'h0AAA}) begin
            n_err++;
            $display("FAIL single_unmerge: got %h want 4444333311110aaa", merged0);
        end
        $display("test_single_fault_merge done edges=%0d", edges);
    endtask

    task automatic test_overflow();
        int edges;
        run_alloc(16'h8429, 1'b0, edges);
        n_vec++;
        if (ru_en0 !== 4'b1111 || row_map0 !== 8'h90 || col_map0 !== 8'h9C) begin
            n_err++;
            $display("FAIL overflow_map: got en=%b row=%h col=%h want 1111/90/9c",
                     ru_en0, row_map0, col_map0);
        end
        n_vec++;
        if (fc0 !== 5'd5 || unrep0 !== 1'b1 || edges !== 17) begin
            n_err++;
            $display("FAIL overflow_flags: got fc=%0d un=%b edges=%0d want 5/1/17", fc0, unrep0, edges);
        end
        $display("test_overflow done edges=%0d", edges);
    endtask

    task automatic test_col_major();
        int edges;
        run_alloc(16'h0018, 1'b0, edges);
        n_vec++;
        if (ru_en1 !== 4'b0011 || row_map1 !== 8'h01 || col_map1 !== 8'h0C || fc1 !== 5'd2) begin
            n_err++;
            $display("FAIL colmajor_map: got en=%b row=%h col=%h fc=%0d want 0011/01/0c/2",
                     ru_en1, row_map1, col_map1, fc1);
        end
        n_vec++;
        if (ru_en0 !== 4'b0011 || row_map0 !== 8'h04 || col_map0 !== 8'h03 || unrep0 !== 1'b0) begin
            n_err++;
            $display("FAIL rowmajor_same_map: got en=%b row=%h col=%h un=%b want 0011/04/03/0",
                     ru_en0, row_map0, col_map0, unrep0);
        end
        $display("test_col_major done edges=%0d", edges);
    endtask

    task automatic test_merge_priority();
        int edges;
        run_alloc(16'h0424, 1'b0, edges);
        n_vec++;
        if (ru_en0 !== 4'b0111 || col_map0 !== 8'h26) begin
            n_err++;
            $display("FAIL prio_alloc: got en=%b col=%h want 0111/26", ru_en0, col_map0);
        end
        @(negedge clk);
        systolic_bottom_out = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        rcm_bottom_out      = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        ru_output_valid     = 4'b0101;
        @(negedge clk);
        n_vec++;
        if (merged0 !== {16'h4444, 16'hAAAA, 16'h2222, 16'h1111}) begin
            n_err++;
            $display("FAIL prio_lowest: got %h want 4444aaaa22221111", merged0);
        end
        ru_output_valid = 4'b0100;
        @(negedge clk);
        n_vec++;
        if (merged0 !== {16'h4444, 16'hCCCC, 16'h2222, 16'h1111}) begin
            n_err++;
            $display("FAIL prio_second: got %h want 4444cccc22221111", merged0);
        end
        ru_output_valid = 4'b1111;
        @(negedge clk);
        n_vec++;
        if (merged0 !== {16'h4444, 16'hAAAA, 16'hBBBB, 16'h1111}) begin
            n_err++;
            $display("FAIL prio_unalloc_ignored: got %h want 4444aaaabbbb1111", merged0);
        end
        ru_output_valid = 4'b0000;
        $display("test_merge_priority done edges=%0d", edges);
    endtask

    task automatic test_reset_mid_scan();
        int edges;
        @(negedge clk);
        systolic_bottom_out = 64'h5555_6666_7777_8888;
        stw_result_mat = 16'h1002;
        stw_complete   = 1'b1;
        alloc_start    = 1'b1;
        @(negedge clk);
        alloc_start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        n_vec++;
        if (ru_en0 !== 4'b0001 || done0 !== 1'b0) begin
            n_err++;
            $display("FAIL midscan_progress: got en=%b done=%b want 0001/0", ru_en0, done0);
        end
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({ru_en0, row_map0, col_map0, fc0, unrep0, done0} !== '0 || merged0 !== 64'h0) begin
            n_err++;
            $display("FAIL midscan_reset: got en=%b row=%h col=%h fc=%0d un=%b done=%b m=%h want all 0",
                     ru_en0, row_map0, col_map0, fc0, unrep0, done0, merged0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++;
        if (done0 !== 1'b0 || ru_en0 !== 4'b0000) begin
            n_err++;
            $display("FAIL midscan_idle: got done=%b en=%b want 0/0000", done0, ru_en0);
        end
        run_alloc(16'h0040, 1'b0, edges);
        n_vec++;
        if (edges !== 17 || ru_en0 !== 4'b0001 || row_map0 !== 8'h01 || col_map0 !== 8'h02 ||
            fc0 !== 5'd1 || unrep0 !== 1'b0) begin
            n_err++;
            $display("FAIL restart_clean: got edges=%0d en=%b row=%h col=%h fc=%0d un=%b want 17/0001/01/02/1/0",
                     edges, ru_en0, row_map0, col_map0, fc0, unrep0);
        end
        $display("test_reset_mid_scan done edges=%0d", edges);
    endtask

    initial begin
        test_reset();
        test_ignore_no_complete();
        test_empty_map();
        test_single_fault_merge();
        test_overflow();
        test_col_major();
        test_merge_priority();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bisr_ru_allocator_os.md
Name: bisr_ru_allocator_os

Overview:
Parametrised successor to the output-stationary BISR top-level glue. It takes a snapshot of the STW fault map. It then runs a sequential scan that assigns up to NUM_RU recompute units (RUs) to faulty PEs, in either row-major or column-major priority, and flags arrays that cannot be repaired. Once allocation is finished, it drives a registered bottom-output bus in which valid RU results replace the systolic column outputs. It sits between traditional_systolic_stw, recompute_module and the output regfile.

Parameters:
ROWS, 4, systolic rows (>=2)
COLS, 4, systolic columns (>=2)
WORD_SIZE, 16, datapath word width
NUM_RU, 4, number of recompute units (>=1)
SCAN_MODE, 0, 0 = row-major allocation priority; 1 = column-major

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stw_complete  in  1  STW test finished; fault map is stable
stw_result_mat  in  ROWS*COLS  1 = PE faulty; bit index r*COLS+c
alloc_start  in  1  single-cycle request to (re)run allocation
systolic_bottom_out  in  COLS*WORD_SIZE  array column outputs
rcm_bottom_out  in  NUM_RU*WORD_SIZE  RU outputs, slot k at [k*WORD_SIZE+:WORD_SIZE]
ru_output_valid  in  NUM_RU  RU slot result valid
ru_en  out  NUM_RU  slot allocated
ru_row_mapping  out  clog2(ROWS)*NUM_RU  row of PE covered by each slot
ru_col_mapping  out  clog2(COLS)*NUM_RU  column of PE covered by each slot
fault_count  out  clog2(ROWS*COLS+1)  total faulty PEs found
unrepairable  out  1  faults exceeded NUM_RU
alloc_done  out  1  allocation complete; mappings valid
merged_bottom_out  out  COLS*WORD_SIZE  corrected column outputs

Behaviour:
- Reset (async, any state): FSM goes to IDLE. All outputs are 0, including the mappings, fault_count and merged_bottom_out. The scan index and slot pointer are cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN when alloc_start=1 and stw_complete=1.
  - alloc_start while stw_complete=0 is ignored.
- DONE -> SCAN under the same condition.
- alloc_start while in SCAN is ignored.
- On SCAN entry (the edge that samples alloc_start):
  - Latch stw_result_mat into an internal snapshot.
  - Clear ru_en, the mappings, fault_count, unrepairable and alloc_done.
  - Set scan index i=0 and slot pointer s=0.
- SCAN visits one PE per cycle, i=0..ROWS*COLS-1.
  - SCAN_MODE=0: PE (i/COLS, i%COLS).
  - SCAN_MODE=1: PE (i%ROWS, i/ROWS).
- Visited PE faulty and s<NUM_RU:
  - Set ru_en[s]=1 and write the row/column into slot s.
  - s increments.
  - fault_count increments.
- Visited PE faulty and s==NUM_RU: unrepairable is set (sticky until the next SCAN entry). fault_count still increments.
- After the last index the FSM goes to DONE and alloc_done=1. alloc_done holds until the next SCAN entry or reset.
  - Latency: alloc_done rises ROWS*COLS+1 rising edges after the edge that samples alloc_start (17 for 4x4).
- fault_count never wraps, because its width covers ROWS*COLS.
- Merge logic is registered, with 1-cycle latency, and is updated every cycle.
  - In IDLE/SCAN: merged_bottom_out <= systolic_bottom_out (pass-through).
  - In DONE, for each column c: if any slot k has ru_en[k]=1, ru_col_mapping[k]==c and ru_output_valid[k]=1, the column takes rcm_bottom_out slot k. Otherwise it takes systolic_bottom_out column c.
  - If several slots match one column, the lowest k wins.
  - ru_output_valid on an unallocated slot is ignored.
- Mappings of unallocated slots stay 0. Consumers must qualify every mapping with ru_en.
- stw_result_mat changes during SCAN have no effect, because the scan reads the snapshot.

Test Plan:
1. 4x4, NUM_RU=4: stw_result_mat=0, alloc_start -> alloc_done at edge 17, ru_en=0, fault_count=0, unrepairable=0; merged output equals systolic input delayed 1 cycle.
2. Single fault at bit 9 (row 2, col 1) -> ru_en=4'b0001, slot0 row=2/col=1, fault_count=1. In DONE with systolic col1=16'h1111, rcm slot0=16'hBEEF, ru_output_valid[0]=1 -> merged col1=16'hBEEF one cycle later; other columns pass through. Dropping valid restores 16'h1111.
3. Faults at bits 0,3,5,10,15, SCAN_MODE=0 -> slots (0,0),(0,3),(1,1),(2,2), ru_en=4'b1111, fault_count=5, unrepairable=1.
4. SCAN_MODE=1, faults at bits 3 (0,3) and 4 (1,0) -> slot0=(1,0), slot1=(0,3), ru_en=4'b0011.
5. Slots 0 and 2 both mapped to col 2, both valid, values 16'hAAAA / 16'hCCCC -> merged col2=16'hAAAA.
6. alloc_start with stw_complete=0 -> stays IDLE. Assert rst at scan index 7 -> all outputs 0 immediately, FSM in IDLE. Restart with a new map -> clean result, no stale slots.
